// File: rtl/dbus_arb_pkg.sv
// Shared types for the two-master data-bus arbiter.
// Address, data and mask stay as parameterized vectors outside the struct.
package dbus_arb_pkg;

  localparam int ID_W = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       wr;
    logic       uncached;
    logic       last;
    logic [2:0] size;
  } dbus_cmd_t;

endpackage

// File: rtl/dbus_arb_id_fifo.sv
// Synchronous FIFO of requester IDs, one entry per outstanding read.
// Head is read combinationally so responses can be routed in the same cycle.
module dbus_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  assign head_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for a cmd/rsp data bus with write-burst locking and in-order read routing.
// Build option: DBUS_ARB_FIXED_PRIO_EN selects fixed priority (port 0) instead of round-robin.
module dbus_arbiter
  import dbus_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                s0_cmd_valid,
  output logic                s0_cmd_ready,
  input  logic                s0_cmd_payload_wr,
  input  logic                s0_cmd_payload_uncached,
  input  logic                s0_cmd_payload_last,
  input  logic [ADDR_W-1:0]   s0_cmd_payload_address,
  input  logic [DATA_W-1:0]   s0_cmd_payload_data,
  input  logic [DATA_W/8-1:0] s0_cmd_payload_mask,
  input  logic [2:0]          s0_cmd_payload_size,
  output logic                s0_rsp_valid,
  output logic                s0_rsp_payload_last,
  output logic                s0_rsp_payload_error,
  output logic [DATA_W-1:0]   s0_rsp_payload_data,

  input  logic                s1_cmd_valid,
  output logic                s1_cmd_ready,
  input  logic                s1_cmd_payload_wr,
  input  logic                s1_cmd_payload_uncached,
  input  logic                s1_cmd_payload_last,
  input  logic [ADDR_W-1:0]   s1_cmd_payload_address,
  input  logic [DATA_W-1:0]   s1_cmd_payload_data,
  input  logic [DATA_W/8-1:0] s1_cmd_payload_mask,
  input  logic [2:0]          s1_cmd_payload_size,
  output logic                s1_rsp_valid,
  output logic                s1_rsp_payload_last,
  output logic                s1_rsp_payload_error,
  output logic [DATA_W-1:0]   s1_rsp_payload_data,

  output logic                m_cmd_valid,
  input  logic                m_cmd_ready,
  output logic                m_cmd_payload_wr,
  output logic                m_cmd_payload_uncached,
  output logic                m_cmd_payload_last,
  output logic [ADDR_W-1:0]   m_cmd_payload_address,
  output logic [DATA_W-1:0]   m_cmd_payload_data,
  output logic [DATA_W/8-1:0] m_cmd_payload_mask,
  output logic [2:0]          m_cmd_payload_size,
  input  logic                m_rsp_valid,
  input  logic                m_rsp_payload_last,
  input  logic                m_rsp_payload_error,
  input  logic [DATA_W-1:0]   m_rsp_payload_data,

  output logic                orphan_rsp
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  logic [1:0]        cmd_valid;
  dbus_cmd_t         ctrl  [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic [MASK_W-1:0] mask  [2];
  logic [1:0]        cmd_ready;
  logic [1:0]        rsp_valid;

  arb_state_e        state_reg, state_next;
  logic              hold_reg, hold_next;
  logic [ID_W-1:0]   hold_port_reg;
  logic              orphan_reg;
`ifndef DBUS_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]   rr_ptr_reg;
`endif

  logic [ID_W-1:0]   sel;
  dbus_cmd_t         sel_ctrl;
  logic              req_valid;
  logic              blocked;
  logic              fwd_valid;
  logic              accept;

  logic              fifo_push;
  logic              fifo_pop;
  logic [ID_W-1:0]   fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  // Occupancy is exported by the FIFO for debug; the arbiter only needs full/empty.
  logic [CNT_W-1:0]  fifo_count_unused;

  assign cmd_valid = {s1_cmd_valid, s0_cmd_valid};
  assign ctrl[0]   = '{wr: s0_cmd_payload_wr, uncached: s0_cmd_payload_uncached,
                       last: s0_cmd_payload_last, size: s0_cmd_payload_size};
  assign ctrl[1]   = '{wr: s1_cmd_payload_wr, uncached: s1_cmd_payload_uncached,
                       last: s1_cmd_payload_last, size: s1_cmd_payload_size};
  assign addr[0]   = s0_cmd_payload_address;
  assign addr[1]   = s1_cmd_payload_address;
  assign wdata[0]  = s0_cmd_payload_data;
  assign wdata[1]  = s1_cmd_payload_data;
  assign mask[0]   = s0_cmd_payload_mask;
  assign mask[1]   = s1_cmd_payload_mask;

  always_comb begin
    state_next = state_reg;
    sel        = '0;
    req_valid  = 1'b0;
    cmd_ready  = '0;
    case (state_reg)
      IDLE: begin
        // A stalled offer keeps its port so the forwarded payload cannot switch.
        if (hold_reg) begin
          sel = hold_port_reg;
        end else if (cmd_valid == 2'b11) begin
`ifdef DBUS_ARB_FIXED_PRIO_EN
          sel = '0;
`else
          sel = ~rr_ptr_reg;
`endif
        end else begin
          sel = cmd_valid[1] ? ID_W'(1) : ID_W'(0);
        end
      end
      LOCK0:   sel = ID_W'(0);
      LOCK1:   sel = ID_W'(1);
      default: sel = '0;
    endcase
    req_valid = cmd_valid[sel];
    sel_ctrl  = ctrl[sel];
    blocked   = !sel_ctrl.wr && fifo_full;
    fwd_valid = req_valid && !blocked && !reset;
    accept    = fwd_valid && m_cmd_ready;
    if (!blocked && !reset) begin
      cmd_ready[sel] = m_cmd_ready;
    end
    if (accept) begin
      if (sel_ctrl.last) state_next = IDLE;
      else               state_next = (sel != '0) ? LOCK1 : LOCK0;
    end
    hold_next = (state_reg == IDLE) && fwd_valid && !m_cmd_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      hold_reg      <= 1'b0;
      hold_port_reg <= '0;
      orphan_reg    <= 1'b0;
`ifndef DBUS_ARB_FIXED_PRIO_EN
      rr_ptr_reg    <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      hold_port_reg <= sel;
      if (m_rsp_valid && fifo_empty) orphan_reg <= 1'b1;
`ifndef DBUS_ARB_FIXED_PRIO_EN
      if (accept && sel_ctrl.last) rr_ptr_reg <= sel;
`endif
    end
  end

  assign fifo_push = accept && !sel_ctrl.wr && sel_ctrl.last;
  assign fifo_pop  = m_rsp_valid && m_rsp_payload_last;

  dbus_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .srst      (reset),
    .push      (fifo_push),
    .push_data (sel),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_valid[gi] = m_rsp_valid && !fifo_empty && !reset && (fifo_head == ID_W'(gi));
    end
  endgenerate

  assign s0_cmd_ready           = cmd_ready[0];
  assign s1_cmd_ready           = cmd_ready[1];
  assign m_cmd_valid            = fwd_valid;
  assign m_cmd_payload_wr       = sel_ctrl.wr;
  assign m_cmd_payload_uncached = sel_ctrl.uncached;
  assign m_cmd_payload_last     = sel_ctrl.last;
  assign m_cmd_payload_size     = sel_ctrl.size;
  assign m_cmd_payload_address  = addr[sel];
  assign m_cmd_payload_data     = wdata[sel];
  assign m_cmd_payload_mask     = mask[sel];

  assign s0_rsp_valid           = rsp_valid[0];
  assign s0_rsp_payload_last    = m_rsp_payload_last;
  assign s0_rsp_payload_error   = m_rsp_payload_error;
  assign s0_rsp_payload_data    = m_rsp_payload_data;
  assign s1_rsp_valid           = rsp_valid[1];
  assign s1_rsp_payload_last    = m_rsp_payload_last;
  assign s1_rsp_payload_error   = m_rsp_payload_error;
  assign s1_rsp_payload_data    = m_rsp_payload_data;

  assign orphan_rsp             = orphan_reg;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: expected responses are queued at issue time
// and matched against routed response beats; the bench acts as the downstream slave.
module tb_dbus_arbiter;
  import dbus_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_cmd_valid, s0_cmd_ready, s0_cmd_payload_wr, s0_cmd_payload_uncached, s0_cmd_payload_last;
  logic [31:0] s0_cmd_payload_address, s0_cmd_payload_data;
  logic [3:0]  s0_cmd_payload_mask;
  logic [2:0]  s0_cmd_payload_size;
  logic        s0_rsp_valid, s0_rsp_payload_last, s0_rsp_payload_error;
  logic [31:0] s0_rsp_payload_data;
  logic        s1_cmd_valid, s1_cmd_ready, s1_cmd_payload_wr, s1_cmd_payload_uncached, s1_cmd_payload_last;
  logic [31:0] s1_cmd_payload_address, s1_cmd_payload_data;
  logic [3:0]  s1_cmd_payload_mask;
  logic [2:0]  s1_cmd_payload_size;
  logic        s1_rsp_valid, s1_rsp_payload_last, s1_rsp_payload_error;
  logic [31:0] s1_rsp_payload_data;
  logic        m_cmd_valid, m_cmd_ready, m_cmd_payload_wr, m_cmd_payload_uncached, m_cmd_payload_last;
  logic [31:0] m_cmd_payload_address, m_cmd_payload_data;
  logic [3:0]  m_cmd_payload_mask;
  logic [2:0]  m_cmd_payload_size;
  logic        m_rsp_valid, m_rsp_payload_last, m_rsp_payload_error;
  logic [31:0] m_rsp_payload_data;
  logic        orphan_rsp;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] slave_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dbus_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready),
    .s0_cmd_payload_wr(s0_cmd_payload_wr), .s0_cmd_payload_uncached(s0_cmd_payload_uncached),
    .s0_cmd_payload_last(s0_cmd_payload_last), .s0_cmd_payload_address(s0_cmd_payload_address),
    .s0_cmd_payload_data(s0_cmd_payload_data), .s0_cmd_payload_mask(s0_cmd_payload_mask),
    .s0_cmd_payload_size(s0_cmd_payload_size),
    .s0_rsp_valid(s0_rsp_valid), .s0_rsp_payload_last(s0_rsp_payload_last),
    .s0_rsp_payload_error(s0_rsp_payload_error), .s0_rsp_payload_data(s0_rsp_payload_data),
    .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready),
    .s1_cmd_payload_wr(s1_cmd_payload_wr), .s1_cmd_payload_uncached(s1_cmd_payload_uncached),
    .s1_cmd_payload_last(s1_cmd_payload_last), .s1_cmd_payload_address(s1_cmd_payload_address),
    .s1_cmd_payload_data(s1_cmd_payload_data), .s1_cmd_payload_mask(s1_cmd_payload_mask),
    .s1_cmd_payload_size(s1_cmd_payload_size),
    .s1_rsp_valid(s1_rsp_valid), .s1_rsp_payload_last(s1_rsp_payload_last),
    .s1_rsp_payload_error(s1_rsp_payload_error), .s1_rsp_payload_data(s1_rsp_payload_data),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_payload_wr(m_cmd_payload_wr), .m_cmd_payload_uncached(m_cmd_payload_uncached),
    .m_cmd_payload_last(m_cmd_payload_last), .m_cmd_payload_address(m_cmd_payload_address),
    .m_cmd_payload_data(m_cmd_payload_data), .m_cmd_payload_mask(m_cmd_payload_mask),
    .m_cmd_payload_size(m_cmd_payload_size),
    .m_rsp_valid(m_rsp_valid), .m_rsp_payload_last(m_rsp_payload_last),
    .m_rsp_payload_error(m_rsp_payload_error), .m_rsp_payload_data(m_rsp_payload_data),
    .orphan_rsp(orphan_rsp)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rsp_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int port, input logic v, input logic wr, input logic last,
                           input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    if (port == 0) begin
      s0_cmd_valid = v; s0_cmd_payload_wr = wr; s0_cmd_payload_uncached = 1'b1;
      s0_cmd_payload_last = last; s0_cmd_payload_address = a; s0_cmd_payload_data = d;
      s0_cmd_payload_mask = 4'hF; s0_cmd_payload_size = sz;
    end else begin
      s1_cmd_valid = v; s1_cmd_payload_wr = wr; s1_cmd_payload_uncached = 1'b1;
      s1_cmd_payload_last = last; s1_cmd_payload_address = a; s1_cmd_payload_data = d;
      s1_cmd_payload_mask = 4'hF; s1_cmd_payload_size = sz;
    end
  endtask

  // Slave model: one response beat for the oldest read seen on the downstream port.
  task automatic send_rsp();
    logic [31:0] a;
    if (slave_q.size() == 0) begin
      check_val("slave_q_nonempty", 0, 1);
      return;
    end
    a = slave_q.pop_front();
    m_rsp_valid = 1'b1; m_rsp_payload_last = 1'b1; m_rsp_payload_data = rsp_data(a);
    tick();
    m_rsp_valid = 1'b0;
  endtask

  // Monitor: record accepted reads for the slave, score every routed response beat.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_cmd_valid && m_cmd_ready && !m_cmd_payload_wr && m_cmd_payload_last)
        slave_q.push_back(m_cmd_payload_address);
      if (s0_rsp_valid || s1_rsp_valid) begin
        $display("rsp -> s%0d data=%h", s1_rsp_valid ? 1 : 0,
                 s1_rsp_valid ? s1_rsp_payload_data : s0_rsp_payload_data);
        check_val("rsp_onehot", s0_rsp_valid && s1_rsp_valid, 0);
        if (exp_q.size() == 0) begin
          check_val("rsp_expected", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("rsp_port", s1_rsp_valid, e.port);
          check_val("rsp_data", s1_rsp_valid ? s1_rsp_payload_data : s0_rsp_payload_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a0, a1, a;
    int          beat;
    bit          exp_gnt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; m_cmd_ready = 1'b1;
    m_rsp_valid = 1'b0; m_rsp_payload_last = 1'b0; m_rsp_payload_error = 1'b0; m_rsp_payload_data = '0;
    drive_cmd(0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 3'd2);
    drive_cmd(1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'd2);
    tick();
    check_val("rst_s0_ready", s0_cmd_ready, 0);
    check_val("rst_m_valid", m_cmd_valid, 0);
    tick();
    check_val("rst_state", dut.state_reg, IDLE);
    check_val("rst_fifo_empty", dut.fifo_empty, 1);
    check_val("rst_orphan", orphan_rsp, 0);
    check_val("rst_rsp_valid", {s0_rsp_valid, s1_rsp_valid}, 0);
    reset = 1'b0; s0_cmd_valid = 1'b0;
    tick();

    // Single read from s0, zero-latency forward, response after 3 idle cycles.
    drive_cmd(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 3'd2);
    #1;
    check_val("rd_m_valid", m_cmd_valid, 1);
    check_val("rd_m_addr", m_cmd_payload_address, 32'h100);
    check_val("rd_m_uncached", m_cmd_payload_uncached, 1);
    check_val("rd_m_size", m_cmd_payload_size, 2);
    check_val("rd_s0_ready", s0_cmd_ready, 1);
    exp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF});
    tick();
    s0_cmd_valid = 1'b0;
    repeat (3) tick();
    a = (slave_q.size() != 0) ? slave_q.pop_front() : 32'h0;
    m_rsp_valid = 1'b1; m_rsp_payload_last = 1'b1; m_rsp_payload_error = 1'b1;
    m_rsp_payload_data = rsp_data(a);
    #1;
    check_val("rd_s0_rsp_valid", s0_rsp_valid, 1);
    check_val("rd_s1_rsp_valid", s1_rsp_valid, 0);
    check_val("rd_rsp_error", s0_rsp_payload_error, 1);
    check_val("rd_rsp_last", s0_rsp_payload_last, 1);
    tick();
    m_rsp_valid = 1'b0; m_rsp_payload_error = 1'b0;
    #1;
    check_val("rd_fifo_empty", dut.fifo_empty, 1);

    // Contention: both masters hold a read each cycle; grants must alternate 1,0,1,0.
    a0 = 32'h200; a1 = 32'h300;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(0, 1'b1, 1'b0, 1'b1, a0, 32'h0, 3'd2);
      drive_cmd(1, 1'b1, 1'b0, 1'b1, a1, 32'h0, 3'd2);
      #1;
      check_val("gnt_s1_ready", s1_cmd_ready, exp_gnt[i]);
      check_val("gnt_s0_ready", s0_cmd_ready, !exp_gnt[i]);
      check_val("gnt_m_addr", m_cmd_payload_address, exp_gnt[i] ? a1 : a0);
      exp_q.push_back('{port: exp_gnt[i], data: rsp_data(exp_gnt[i] ? a1 : a0)});
      if (exp_gnt[i]) a1 += 32'd4; else a0 += 32'd4;
      tick();
    end
    s0_cmd_valid = 1'b0; s1_cmd_valid = 1'b0;
    repeat (4) send_rsp();

    // Burst lock: s1 4-beat write while s0 waits, with m_cmd_ready toggling.
    beat = 0;
    drive_cmd(0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 3'd2);
    for (int c = 0; c < 20 && beat < 4; c++) begin
      m_cmd_ready = (c % 2 == 0);
      drive_cmd(1, 1'b1, 1'b1, beat == 3, 32'h400 + 32'(beat * 4), 32'h1000 + 32'(beat), 3'd4);
      #1;
      check_val("lock_s0_ready", s0_cmd_ready, 0);
      check_val("lock_m_valid", m_cmd_valid, 1);
      check_val("lock_m_addr", m_cmd_payload_address, 32'h400 + 32'(beat * 4));
      check_val("lock_m_data", m_cmd_payload_data, 32'h1000 + 32'(beat));
      check_val("lock_m_wr", m_cmd_payload_wr, 1);
      if (m_cmd_ready) beat++;
      tick();
    end
    s1_cmd_valid = 1'b0; m_cmd_ready = 1'b1;
    #1;
    check_val("unlock_s0_ready", s0_cmd_ready, 1);
    check_val("unlock_m_addr", m_cmd_payload_address, 32'h500);
    exp_q.push_back('{port: 1'b0, data: rsp_data(32'h500)});
    tick();
    s0_cmd_valid = 1'b0;
    send_rsp();

    // FIFO full: four reads fill it, the fifth waits until the cycle after a pop.
    for (int i = 0; i < 4; i++) begin
      drive_cmd(0, 1'b1, 1'b0, 1'b1, 32'h600 + 32'(i * 4), 32'h0, 3'd2);
      #1;
      check_val("fill_s0_ready", s0_cmd_ready, 1);
      exp_q.push_back('{port: 1'b0, data: rsp_data(32'h600 + 32'(i * 4))});
      tick();
    end
    drive_cmd(0, 1'b1, 1'b0, 1'b1, 32'h610, 32'h0, 3'd2);
    #1;
    check_val("full_s0_ready", s0_cmd_ready, 0);
    check_val("full_m_valid", m_cmd_valid, 0);
    tick();
    check_val("full_hold_ready", s0_cmd_ready, 0);
    a = (slave_q.size() != 0) ? slave_q.pop_front() : 32'h0;
    m_rsp_valid = 1'b1; m_rsp_payload_last = 1'b1; m_rsp_payload_data = rsp_data(a);
    #1;
    check_val("full_pop_cycle_ready", s0_cmd_ready, 0);
    tick();
    m_rsp_valid = 1'b0;
    #1;
    check_val("full_after_pop_ready", s0_cmd_ready, 1);
    exp_q.push_back('{port: 1'b0, data: rsp_data(32'h610)});
    tick();
    s0_cmd_valid = 1'b0;
    repeat (4) send_rsp();

    // Orphan: response with nothing outstanding.
    m_rsp_valid = 1'b1; m_rsp_payload_last = 1'b1; m_rsp_payload_data = 32'h1234;
    #1;
    check_val("orph_rsp_valid", {s0_rsp_valid, s1_rsp_valid}, 0);
    check_val("orph_same_cycle", orphan_rsp, 0);
    tick();
    m_rsp_valid = 1'b0;
    check_val("orph_set", orphan_rsp, 1);
    tick();
    check_val("orph_sticky", orphan_rsp, 1);

    // Reset mid-burst with a read outstanding.
    drive_cmd(0, 1'b1, 1'b0, 1'b1, 32'h700, 32'h0, 3'd2);
    tick();
    s0_cmd_valid = 1'b0;
    drive_cmd(1, 1'b1, 1'b1, 1'b0, 32'h800, 32'h1, 3'd4);
    tick();
    drive_cmd(1, 1'b1, 1'b1, 1'b0, 32'h804, 32'h2, 3'd4);
    drive_cmd(0, 1'b1, 1'b0, 1'b1, 32'h900, 32'h0, 3'd2);
    reset = 1'b1;
    #1;
    check_val("mid_rst_s0_ready", s0_cmd_ready, 0);
    check_val("mid_rst_s1_ready", s1_cmd_ready, 0);
    check_val("mid_rst_m_valid", m_cmd_valid, 0);
    tick();
    reset = 1'b0; s0_cmd_valid = 1'b0; s1_cmd_valid = 1'b0;
    slave_q.delete();
    #1;
    check_val("post_rst_state", dut.state_reg, IDLE);
    check_val("post_rst_fifo_empty", dut.fifo_empty, 1);
    check_val("post_rst_orphan", orphan_rsp, 0);
    m_rsp_valid = 1'b1; m_rsp_payload_last = 1'b1; m_rsp_payload_data = rsp_data(32'h700);
    #1;
    check_val("late_rsp_valid", {s0_rsp_valid, s1_rsp_valid}, 0);
    tick();
    m_rsp_valid = 1'b0;
    check_val("late_orphan", orphan_rsp, 1);
    tick();
    check_val("rsp_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
